fmap_packer: RTL and testbench

Streaming-to-parallel feature-map packer that sits directly upstream of the combinational 2-D max-pool stage. It accepts one signed fixed-point element per cycle over a valid/ready stream in channel-major, row-major order. It assembles a complete CH×IN_H×IN_W map into the flat vector layout the pool stage consumes, then holds that vector under a valid/ready output handshake. It also checks frame framing against an end-of-frame marker.

---
 rtl/fmap_packer.sv | 115 +++++++++++
 tb/tb_fmap_packer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fmap_packer.sv
// Streaming-to-parallel packer: collects CH*IN_H*IN_W signed elements into a flat
// vector for the max-pool stage, holds it under valid/ready and flags framing errors.
module fmap_packer #(
  parameter int CH    = 1,
  parameter int IN_H  = 2,
  parameter int IN_W  = 2,
  parameter int WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  input  logic                          in_last,
  output logic [CH*IN_H*IN_W*WIDTH-1:0] out_vec,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          err_frame
);

  localparam int N  = CH * IN_H * IN_W;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(N - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [CW-1:0]   wr_idx;
  logic            wr_en;
  logic            err_nx;
  logic            accept;

  assign in_ready  = (state == FILL) || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == FULL);

  // NOTE: every signal driven here gets a default first so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    err_nx   = 1'b0;
    wr_en    = 1'b0;
    wr_idx   = cnt;
    unique case (state)
      FILL: begin
        if (accept) begin
          wr_en = 1'b1;
          if (cnt == LAST_SLOT) begin
            state_nx = FULL;
            cnt_nx   = '0;
            err_nx   = !in_last;
          end else if (in_last) begin
            // Short frame: the partial map is abandoned, stale slots stay as-is.
            cnt_nx = '0;
            err_nx = 1'b1;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_nx = FILL;
          cnt_nx   = '0;
          if (accept) begin
            // The element arriving during handoff opens the next frame at slot 0.
            wr_en  = 1'b1;
            wr_idx = '0;
            if (N == 1) begin
              state_nx = FULL;
              err_nx   = !in_last;
            end else if (in_last) begin
              err_nx = 1'b1;
            end else begin
              cnt_nx = CW'(1);
            end
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update
  // from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      err_frame <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      err_frame <= err_nx;
    end
  end

  // NOTE: the frame buffer is reset because downstream sees out_vec=0 after reset;
  // a plain storage array with no such visibility would not need it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vec <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        if (wr_idx == CW'(k)) out_vec[k*WIDTH +: WIDTH] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_fmap_packer.sv
// Directed bench for fmap_packer at default parameters (1x2x2 map, 16-bit elements).
module tb_fmap_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic [63:0] out_vec;
  logic        out_valid;
  logic        out_ready;
  logic        err_frame;

  int total = 0;
  int bad   = 0;

  logic [63:0] held;
  logic [15:0] fe [4];

  fmap_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_vec   (out_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_frame (err_frame)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic drive(input logic [15:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_vec", out_vec, 64'd0);
    check("reset_err", 64'(err_frame), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Frame A, with out_valid checked to stay low until the cycle after the 4th accept.
    drive(16'h0100, 1'b0); tick();
    drive(16'hFF00, 1'b0); tick();
    drive(16'h0080, 1'b0); tick();
    check("a_not_yet_valid", 64'(out_valid), 64'd0);
    drive(16'h7FFF, 1'b1); tick();
    check("a_valid", 64'(out_valid), 64'd1);
    check("a_vec", out_vec, 64'h7FFF_0080_FF00_0100);
    check("a_err", 64'(err_frame), 64'd0);

    // Backpressure: data offered but must not be written.
    drive(16'h1234, 1'b0);
    #1;
    check("stall_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_vec", out_vec, 64'h7FFF_0080_FF00_0100);
    end
    drive(16'h1111, 1'b0);
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("release_valid_drop", 64'(out_valid), 64'd0);
    check("release_slot0", out_vec, 64'h7FFF_0080_FF00_1111);
    drive(16'h2222, 1'b0); tick();
    drive(16'h3333, 1'b0); tick();
    drive(16'h4444, 1'b1); tick();
    check("b_valid", 64'(out_valid), 64'd1);
    check("b_vec", out_vec, 64'h4444_3333_2222_1111);

    // Three back-to-back frames with no bubbles.
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        fe[k] = 16'hA000 + 16'(f * 256) + 16'(k);
        check("stream_in_ready", 64'(in_ready), 64'd1);
        drive(fe[k], k == 3);
        tick();
        check("stream_valid", 64'(out_valid), (k == 3) ? 64'd1 : 64'd0);
        check("stream_err", 64'(err_frame), 64'd0);
      end
      check("stream_vec", out_vec, pack4(fe[0], fe[1], fe[2], fe[3]));
    end
    held = pack4(fe[0], fe[1], fe[2], fe[3]);
    in_valid = 1'b0;
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_vec_kept", out_vec, held);

    // Short frame: in_last on the 2nd element.
    drive(16'h0A01, 1'b0); tick();
    drive(16'h0A02, 1'b1); tick();
    check("short_err", 64'(err_frame), 64'd1);
    check("short_valid", 64'(out_valid), 64'd0);
    drive(16'h0B01, 1'b0); tick();
    check("short_err_one_cycle", 64'(err_frame), 64'd0);
    drive(16'h0B02, 1'b0); tick();
    drive(16'h0B03, 1'b0); tick();
    check("short_next_not_valid", 64'(out_valid), 64'd0);
    drive(16'h0B04, 1'b1); tick();
    check("after_short_valid", 64'(out_valid), 64'd1);
    check("after_short_vec", out_vec, 64'h0B04_0B03_0B02_0B01);
    check("after_short_err", 64'(err_frame), 64'd0);

    // Long/unmarked frame: no in_last on the 4th element.
    drive(16'h0C01, 1'b0); tick();
    drive(16'h0C02, 1'b0); tick();
    drive(16'h0C03, 1'b0); tick();
    drive(16'h0C04, 1'b0); tick();
    check("long_err", 64'(err_frame), 64'd1);
    check("long_valid", 64'(out_valid), 64'd1);
    check("long_vec", out_vec, 64'h0C04_0C03_0C02_0C01);
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    check("long_err_one_cycle", 64'(err_frame), 64'd0);
    check("long_held", 64'(out_valid), 64'd1);

    // Reset while a frame is held, then mid-frame with an element offered.
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_full_valid", 64'(out_valid), 64'd0);
    check("rst_full_vec", out_vec, 64'd0);
    check("rst_full_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    drive(16'h0D01, 1'b0); tick();
    drive(16'h0D02, 1'b0); tick();
    drive(16'h0D03, 1'b0); tick();
    drive(16'h0D04, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_vec", out_vec, 64'd0);
    check("rst_mid_err", 64'(err_frame), 64'd0);
    drive(16'h0E01, 1'b0); tick();
    drive(16'h0E02, 1'b0); tick();
    drive(16'h0E03, 1'b0); tick();
    drive(16'h0E04, 1'b1); tick();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_vec", out_vec, 64'h0E04_0E03_0E02_0E01);
    check("post_rst_err", 64'(err_frame), 64'd0);
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
